stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch datapath. It conditions four raw push-button inputs with synchronisers, debouncers and rising-edge detectors, and runs the run/pause/lap/idle state machine. It owns the seconds prescaler and drives the datapath with a one-cycle `tick` enable, a `sw_clear` pulse, and a `lap_hold` freeze flag for the display path. It sits between the top-level `ui_in` pins and the stopwatch counter/7-segment blocks.

---
 rtl/stopwatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/lap/idle FSM, seconds prescaler.
// Latency: raw button edge to event DEB_CYCLES+3 cycles; event to state/sw_clear 1 cycle; tick registered.
// Backpressure: none; every output is a single-cycle pulse or a level, and the datapath must accept it.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned DEB_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick,
  output logic       sw_clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_TOP = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // Button lanes: bit 0 start, 1 stop, 2 lap, 3 clear.
  logic [3:0]         w_btn;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_deb;
  logic [3:0]         r_deb_d;
  logic [3:0]         r_evt;
  logic [3:0][DW-1:0] r_dcnt;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_clear_nxt;
  logic               r_sw_clear;
  logic               w_counting;
  logic [CW-1:0]      r_cnt;
  logic               r_tick;

  logic               w_ev_start;
  logic               w_ev_stop;
  logic               w_ev_lap;
  logic               w_ev_clear;

  assign w_btn = {btn_clear, btn_lap, btn_stop, btn_start};

  // Synchronise, debounce (level flips after DEB_CYCLES disagreeing samples), and register rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_evt   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_evt   <= r_deb & ~r_deb_d;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DEB_TOP) begin
          r_deb[i]  <= ~r_deb[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_ev_start = r_evt[0];
  assign w_ev_stop  = r_evt[1];
  assign w_ev_lap   = r_evt[2];
  assign w_ev_clear = r_evt[3];

  // Next state: each state checks only its legal events, highest priority first (clear > stop > start > lap).
  always_comb begin
    w_state_nxt = r_state;
    w_clear_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev_clear) begin
          w_clear_nxt = 1'b1;
        end else if (w_ev_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_ev_stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = ST_LAP;
        end
      end
      ST_LAP: begin
        if (w_ev_stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_ev_lap) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (w_ev_clear) begin
          w_state_nxt = ST_IDLE;
          w_clear_nxt = 1'b1;
        end else if (w_ev_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and the registered sw_clear pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sw_clear <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sw_clear <= w_clear_nxt;
    end
  end

  // Prescaler runs in RUN and LAP alike so a lap never disturbs the second cadence; PAUSE keeps the partial second.
  assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_counting && (r_cnt == CNT_TOP);
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (w_counting) begin
        r_cnt <= (r_cnt == CNT_TOP) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign tick     = r_tick;
  assign sw_clear = r_sw_clear;
  assign lap_hold = (r_state == ST_LAP);
  assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios followed by random button traffic against a cycle reference model.
// Latency: outputs compared every cycle at the falling edge after the model has advanced one rising edge.
// Backpressure: not applicable; inputs change only at falling edges.
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int DEB = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_LAP = 2'd3;
  localparam int B_START = 0, B_STOP = 1, B_LAP = 2, B_CLEAR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       tick;
  logic       sw_clear;
  logic       lap_hold;
  logic [1:0] state;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .btn_lap  (btn_lap),
    .btn_clear(btn_clear),
    .tick     (tick),
    .sw_clear (sw_clear),
    .lap_hold (lap_hold),
    .state    (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model, advanced once per rising edge.
  int         cyc = 0;
  logic [3:0] m_dly[$];
  logic [3:0] m_lvl = '0;
  int         m_last_ok[4];
  logic [3:0] m_up_pend = '0;
  logic [3:0] m_evt = '0;
  logic [1:0] m_state = S_IDLE;
  int         m_cnt = 0;
  logic       m_tick = 1'b0;
  logic       m_clr = 1'b0;

  // {legal, destination} for an event in a state.
  function automatic logic [2:0] act(input logic [1:0] st, input int b);
    case (st)
      S_IDLE:  begin if (b == B_CLEAR) return {1'b1, S_IDLE};  if (b == B_START) return {1'b1, S_RUN};  end
      S_RUN:   begin if (b == B_STOP)  return {1'b1, S_PAUSE}; if (b == B_LAP)   return {1'b1, S_LAP};  end
      S_LAP:   begin if (b == B_STOP)  return {1'b1, S_PAUSE}; if (b == B_LAP)   return {1'b1, S_RUN};  end
      default: begin if (b == B_CLEAR) return {1'b1, S_IDLE};  if (b == B_START) return {1'b1, S_RUN};  end
    endcase
    return 3'b000;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] raw);
    logic [3:0] s;
    logic [3:0] up;
    logic [2:0] a;
    logic [1:0] st_n;
    logic       clr_n;
    logic       found;
    logic       running;
    int         prio[4];
    prio = '{B_CLEAR, B_STOP, B_START, B_LAP};
    cyc++;
    if (r) begin
      m_dly.delete();
      m_dly.push_back(4'b0);
      m_dly.push_back(4'b0);
      m_lvl = '0;
      for (int i = 0; i < 4; i++) m_last_ok[i] = cyc;
      m_up_pend = '0;
      m_evt = '0;
      m_state = S_IDLE;
      m_cnt = 0;
      m_tick = 1'b0;
      m_clr = 1'b0;
    end else begin
      m_dly.push_back(raw);
      s = m_dly.pop_front();
      up = '0;
      // A level flips once the synchronised input has disagreed with it for DEB samples in a row.
      for (int i = 0; i < 4; i++) begin
        if (s[i] == m_lvl[i]) begin
          m_last_ok[i] = cyc;
        end else if (cyc - m_last_ok[i] >= DEB) begin
          if (!m_lvl[i]) up[i] = 1'b1;
          m_lvl[i] = ~m_lvl[i];
          m_last_ok[i] = cyc;
        end
      end
      st_n = m_state;
      clr_n = 1'b0;
      found = 1'b0;
      for (int p = 0; p < 4; p++) begin
        a = act(m_state, prio[p]);
        if (!found && m_evt[prio[p]] && a[2]) begin
          found = 1'b1;
          st_n = a[1:0];
          clr_n = (prio[p] == B_CLEAR);
        end
      end
      running = (m_state == S_RUN) || (m_state == S_LAP);
      m_tick = running && (m_cnt == TD - 1);
      if (m_state == S_IDLE) m_cnt = 0;
      else if (running) m_cnt = (m_cnt + 1) % TD;
      m_state = st_n;
      m_clr = clr_n;
      m_evt = m_up_pend;
      m_up_pend = up;
    end
  endtask

  // One clock: drive inputs, advance the model at the rising edge, compare at the falling edge.
  task automatic step(input logic r, input logic [3:0] b);
    rst = r;
    {btn_clear, btn_lap, btn_stop, btn_start} = b;
    @(posedge clk);
    model_edge(r, b);
    @(negedge clk);
    chk("state",    32'(state),       32'(m_state));
    chk("tick",     32'(tick),        32'(m_tick));
    chk("sw_clear", 32'(sw_clear),    32'(m_clr));
    chk("lap_hold", 32'(lap_hold),    32'(m_state == S_LAP));
    chk("cnt",      32'(dut.r_cnt),   32'(m_cnt));
  endtask

  int ticks;
  int first_tick;
  int last_tick;
  int k_evt;
  int pulses;

  initial begin
    @(negedge clk);

    // Reset held for three cycles.
    repeat (3) step(1'b1, 4'b0000);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_tick", 32'(tick), 0);
    chk("rst_sw_clear", 32'(sw_clear), 0);
    chk("rst_lap_hold", 32'(lap_hold), 0);

    // Short glitch on start is filtered.
    repeat (3) step(1'b0, 4'b0001);
    repeat (12) step(1'b0, 4'b0000);
    chk("glitch_state", 32'(state), 32'(S_IDLE));

    // Eight-cycle press starts the watch.
    k_evt = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'b0001);
      if (k_evt == 0 && state === S_RUN) k_evt = k;
    end
    chk("press_latency_ok", 32'(k_evt >= 6 && k_evt <= 8), 1);

    // Fifty cycles of running: five ticks ten apart, first at E+11.
    ticks = 0; first_tick = 0; last_tick = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 4'b0000);
      if (tick === 1'b1) begin
        ticks++;
        if (first_tick == 0) first_tick = k;
        else chk("tick_spacing", 32'(k - last_tick), TD);
        last_tick = k;
        chk("tick_wrap_cnt", 32'(dut.r_cnt), 0);
      end
    end
    chk("first_tick", 32'(first_tick), 32'(k_evt + 2));
    chk("tick_count", 32'(ticks), 5);

    // Stop timed so the prescaler freezes at 6.
    for (int k = 0; k < 20 && dut.r_cnt !== 4'd8; k++) step(1'b0, 4'b0000);
    chk("wait_cnt8", 32'(dut.r_cnt), 8);
    repeat (8) step(1'b0, 4'b0010);
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    chk("pause_cnt", 32'(dut.r_cnt), 6);
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b0000);
      if (tick === 1'b1) ticks++;
    end
    chk("pause_ticks", 32'(ticks), 0);
    chk("pause_cnt_held", 32'(dut.r_cnt), 6);

    // Resume: the partial second completes four cycles after counting restarts.
    k_evt = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'b0001);
      if (k_evt == 0 && state === S_RUN) k_evt = k;
    end
    first_tick = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 4'b0000);
      if (first_tick == 0 && tick === 1'b1) first_tick = k;
    end
    chk("resume_tick", 32'(first_tick + 8 - k_evt), 4);

    // Lap freezes the display while ticks continue; a second lap returns to RUN.
    repeat (8) step(1'b0, 4'b0100);
    chk("lap_state", 32'(state), 32'(S_LAP));
    chk("lap_hold_on", 32'(lap_hold), 1);
    ticks = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 4'b0000);
      if (tick === 1'b1) ticks++;
    end
    chk("lap_ticks", 32'(ticks), 3);
    repeat (8) step(1'b0, 4'b0100);
    repeat (10) step(1'b0, 4'b0000);
    chk("lap2_state", 32'(state), 32'(S_RUN));
    chk("lap_hold_off", 32'(lap_hold), 0);

    // Clear while running is ignored.
    repeat (8) step(1'b0, 4'b1000);
    repeat (10) step(1'b0, 4'b0000);
    chk("clear_in_run", 32'(state), 32'(S_RUN));

    // Clear from PAUSE returns to IDLE with one sw_clear pulse.
    repeat (8) step(1'b0, 4'b0010);
    repeat (10) step(1'b0, 4'b0000);
    chk("stop_state", 32'(state), 32'(S_PAUSE));
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      step(1'b0, (k < 8) ? 4'b1000 : 4'b0000);
      if (sw_clear === 1'b1) pulses++;
    end
    chk("clear_pause_pulses", 32'(pulses), 1);
    chk("clear_pause_state", 32'(state), 32'(S_IDLE));
    chk("clear_pause_cnt", 32'(dut.r_cnt), 0);

    // Clear in IDLE pulses and stays.
    pulses = 0;
    for (int k = 0; k < 18; k++) begin
      step(1'b0, (k < 8) ? 4'b1000 : 4'b0000);
      if (sw_clear === 1'b1) pulses++;
    end
    chk("clear_idle_pulses", 32'(pulses), 1);
    chk("clear_idle_state", 32'(state), 32'(S_IDLE));

    // Stop, lap and start together while running: stop wins.
    repeat (8) step(1'b0, 4'b0001);
    repeat (10) step(1'b0, 4'b0000);
    repeat (8) step(1'b0, 4'b0111);
    repeat (10) step(1'b0, 4'b0000);
    chk("priority_state", 32'(state), 32'(S_PAUSE));

    // Reset in the middle of a second.
    repeat (8) step(1'b0, 4'b0001);
    for (int k = 0; k < 20 && dut.r_cnt !== 4'd5; k++) step(1'b0, 4'b0000);
    chk("wait_cnt5", 32'(dut.r_cnt), 5);
    step(1'b1, 4'b0000);
    chk("midrst_state", 32'(state), 32'(S_IDLE));
    chk("midrst_cnt", 32'(dut.r_cnt), 0);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b0000);
      if (tick === 1'b1) ticks++;
    end
    chk("midrst_ticks", 32'(ticks), 0);

    // Start held through reset counts as a fresh press.
    repeat (3) step(1'b0, 4'b0001);
    repeat (2) step(1'b1, 4'b0001);
    repeat (10) step(1'b0, 4'b0001);
    chk("held_rst_state", 32'(state), 32'(S_RUN));
    repeat (10) step(1'b0, 4'b0000);

    // Random button traffic with occasional resets.
    for (int it = 0; it < 250; it++) begin
      logic [3:0] m;
      int h;
      int g;
      m = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(1, 15));
      h = $urandom_range(1, 10);
      g = $urandom_range(0, 8);
      if ($urandom_range(0, 39) == 0) step(1'b1, 4'b0000);
      repeat (h) step(1'b0, m);
      repeat (g) step(1'b0, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
